// File: rtl/drag_race_pkg.sv
// Shared types and constants for the two-player drag race game logic.
// Imported by race_ctrl and race_car_dyn.
package drag_race_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        RACE      = 2'd2,
        FINISH    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        W_NONE = 2'd0,
        W_P1   = 2'd1,
        W_P2   = 2'd2,
        W_TIE  = 2'd3
    } winner_t;

    localparam int KEY_P1    = 0;
    localparam int KEY_P2    = 1;
    localparam int KEY_OK    = 2;
    localparam int KEY_ABORT = 3;

    localparam int POS_W   = 11;
    localparam int SPEED_W = 4;

    // Maps "P1 wins" / "P2 wins" flags onto a winner code; both set is a tie.
    function automatic winner_t win_code(input logic p1_wins, input logic p2_wins);
        if (p1_wins && p2_wins) return W_TIE;
        if (p1_wins)            return W_P1;
        if (p2_wins)            return W_P2;
        return W_NONE;
    endfunction

endpackage

// File: rtl/race_car_dyn.sv
// One player's speed and position integrator, stepped once per video frame.
// finished is combinational so the controller can resolve ties on the same tick.
module race_car_dyn
    import drag_race_pkg::*;
#(
    parameter int X_START   = 256,
    parameter int X_FINISH  = 900,
    parameter int ACCEL     = 2,
    parameter int MAX_SPEED = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic               tap,
    input  logic               tick,
    input  logic               decay_tick,
    output logic [POS_W-1:0]   pos,
    output logic [SPEED_W-1:0] speed,
    output logic               finished
);

    localparam logic [11:0] FINISH_12 = 12'(X_FINISH);

    logic [11:0]        pos_sum;
    logic [11:0]        pos_next;
    logic [5:0]         spd_sum;
    logic [SPEED_W-1:0] spd_next;

    // Position integrates the pre-update speed; the tap/decay result lands next.
    always_comb begin
        pos_sum  = {1'b0, pos} + {8'd0, speed};
        pos_next = (pos_sum >= FINISH_12) ? FINISH_12 : pos_sum;
        spd_sum  = {2'b00, speed} + (tap ? 6'(ACCEL) : 6'd0);
        if (decay_tick && (speed != '0)) begin
            spd_sum = spd_sum - 6'd1;
        end
        spd_next = (spd_sum > 6'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED) : spd_sum[SPEED_W-1:0];
        finished = enable && tick && (pos_next == FINISH_12);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos   <= POS_W'(X_START);
            speed <= '0;
        end else if (clear) begin
            pos   <= POS_W'(X_START);
            speed <= '0;
        end else if (enable) begin
            speed <= spd_next;
            if (tick) begin
                pos <= pos_next[POS_W-1:0];
            end
        end else begin
            speed <= '0;
        end
    end

endmodule

// File: rtl/race_ctrl.sv
// Drag race game controller: countdown, false-start and finish detection,
// and per-frame motion of both cars for the draw_car pair.
module race_ctrl
    import drag_race_pkg::*;
#(
    parameter int X_START      = 256,
    parameter int X_FINISH     = 900,
    parameter int COUNT_FRAMES = 60,
    parameter int ACCEL        = 2,
    parameter int MAX_SPEED    = 15,
    parameter int DECAY_FRAMES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync_in,
    input  logic             start_game,
    input  logic [3:0]       keyboard_in,
    output logic [POS_W-1:0] xpos_p1,
    output logic [POS_W-1:0] xpos_p2,
    output logic             mov_p1,
    output logic             mov_p2,
    output logic [1:0]       countdown,
    output logic             race_active,
    output logic [1:0]       winner,
    output logic             foul,
    output logic             in_menu
);

    localparam int FR_W = $clog2(COUNT_FRAMES + 1);
    localparam int DC_W = $clog2(DECAY_FRAMES + 1);

    state_t             state_q, state_d;
    logic               vsync_d;
    logic               tick, abort, confirm, tap1, tap2;
    logic               count_wrap, decay_tick;
    logic               car_en, car_clr, fin1, fin2;
    logic [1:0]         cd_q, cd_d;
    logic [FR_W-1:0]    fr_q, fr_d;
    logic [DC_W-1:0]    dc_q, dc_d;
    winner_t            win_q, win_d;
    logic               foul_q, foul_d;
    logic               race_active_q, in_menu_q;
    logic [SPEED_W-1:0] speed_p1, speed_p2;

    assign tick       = vsync_in & ~vsync_d;
    assign abort      = keyboard_in[KEY_ABORT] && (state_q != IDLE);
    assign confirm    = keyboard_in[KEY_OK];
    assign tap1       = keyboard_in[KEY_P1];
    assign tap2       = keyboard_in[KEY_P2];
    assign count_wrap = (fr_q == FR_W'(COUNT_FRAMES - 1));
    assign decay_tick = tick && (state_q == RACE) && (dc_q == DC_W'(DECAY_FRAMES - 1));

    // Cars integrate only while racing; they are parked at the start line
    // whenever the game is (or is about to be) in the menu or the countdown.
    assign car_en  = (state_q == RACE) && !abort;
    assign car_clr = !car_en && ((state_d == IDLE) || (state_d == COUNTDOWN));

    race_car_dyn #(
        .X_START  (X_START),
        .X_FINISH (X_FINISH),
        .ACCEL    (ACCEL),
        .MAX_SPEED(MAX_SPEED)
    ) u_car_p1 (
        .clk       (clk),
        .rst       (rst),
        .clear     (car_clr),
        .enable    (car_en),
        .tap       (tap1),
        .tick      (tick),
        .decay_tick(decay_tick),
        .pos       (xpos_p1),
        .speed     (speed_p1),
        .finished  (fin1)
    );

    race_car_dyn #(
        .X_START  (X_START),
        .X_FINISH (X_FINISH),
        .ACCEL    (ACCEL),
        .MAX_SPEED(MAX_SPEED)
    ) u_car_p2 (
        .clk       (clk),
        .rst       (rst),
        .clear     (car_clr),
        .enable    (car_en),
        .tap       (tap2),
        .tick      (tick),
        .decay_tick(decay_tick),
        .pos       (xpos_p2),
        .speed     (speed_p2),
        .finished  (fin2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (start_game || confirm) state_d = COUNTDOWN;
            COUNTDOWN: begin
                if (tap1 || tap2) begin
                    state_d = FINISH;
                end else if (tick && (cd_q == 2'd1) && count_wrap) begin
                    state_d = RACE;
                end
            end
            RACE:      if (fin1 || fin2) state_d = FINISH;
            FINISH:    if (confirm) state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        cd_d   = cd_q;
        fr_d   = fr_q;
        dc_d   = '0;
        win_d  = win_q;
        foul_d = foul_q;
        unique case (state_q)
            IDLE: begin
                win_d  = W_NONE;
                foul_d = 1'b0;
                if (state_d == COUNTDOWN) begin
                    cd_d = 2'd3;
                    fr_d = '0;
                end
            end
            COUNTDOWN: begin
                if (tap1 || tap2) begin
                    // False start: the player who did not jump the gun wins.
                    cd_d   = 2'd0;
                    fr_d   = '0;
                    win_d  = win_code(tap2, tap1);
                    foul_d = 1'b1;
                end else if (tick) begin
                    if (count_wrap) begin
                        fr_d = '0;
                        cd_d = cd_q - 2'd1;
                    end else begin
                        fr_d = fr_q + FR_W'(1);
                    end
                end
            end
            RACE: begin
                dc_d = dc_q;
                if (tick) begin
                    dc_d = (dc_q == DC_W'(DECAY_FRAMES - 1)) ? '0 : dc_q + DC_W'(1);
                end
                if (fin1 || fin2) begin
                    win_d = win_code(fin1, fin2);
                end
            end
            FINISH: begin
                if (confirm) begin
                    win_d  = W_NONE;
                    foul_d = 1'b0;
                end
            end
        endcase
        if (abort) begin
            cd_d   = 2'd0;
            fr_d   = '0;
            dc_d   = '0;
            win_d  = W_NONE;
            foul_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d       <= 1'b0;
            cd_q          <= 2'd0;
            fr_q          <= '0;
            dc_q          <= '0;
            win_q         <= W_NONE;
            foul_q        <= 1'b0;
            race_active_q <= 1'b0;
            in_menu_q     <= 1'b1;
        end else begin
            vsync_d       <= vsync_in;
            cd_q          <= cd_d;
            fr_q          <= fr_d;
            dc_q          <= dc_d;
            win_q         <= win_d;
            foul_q        <= foul_d;
            race_active_q <= (state_d == RACE);
            in_menu_q     <= (state_d == IDLE);
        end
    end

    assign mov_p1      = (speed_p1 != '0);
    assign mov_p2      = (speed_p2 != '0);
    assign countdown   = cd_q;
    assign race_active = race_active_q;
    assign winner      = win_q;
    assign foul        = foul_q;
    assign in_menu     = in_menu_q;

endmodule

// File: tb/tb_race_ctrl.sv
// Directed bench for race_ctrl with an in-bench game model checked every cycle
// plus hand-computed expectations at key points of each scenario.
module tb_race_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync_in = 1'b0;
    logic        start_game = 1'b0;
    logic [3:0]  keyboard_in = 4'd0;
    logic [10:0] xpos_p1, xpos_p2;
    logic        mov_p1, mov_p2;
    logic [1:0]  countdown;
    logic        race_active;
    logic [1:0]  winner;
    logic        foul;
    logic        in_menu;

    int n_checks = 0;
    int n_errors = 0;

    race_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .vsync_in   (vsync_in),
        .start_game (start_game),
        .keyboard_in(keyboard_in),
        .xpos_p1    (xpos_p1),
        .xpos_p2    (xpos_p2),
        .mov_p1     (mov_p1),
        .mov_p2     (mov_p2),
        .countdown  (countdown),
        .race_active(race_active),
        .winner     (winner),
        .foul       (foul),
        .in_menu    (in_menu)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game model: 0 menu, 1 countdown, 2 racing, 3 finished.
    int m_st, m_x1, m_x2, m_s1, m_s2, m_cd, m_fr, m_dc, m_win, m_foul;
    bit m_vd;

    function automatic int clamp_speed(input int s);
        if (s < 0) return 0;
        if (s > 15) return 15;
        return s;
    endfunction

    task automatic model_idle();
        m_st = 0; m_x1 = 256; m_x2 = 256; m_s1 = 0; m_s2 = 0;
        m_cd = 0; m_fr = 0; m_dc = 0; m_win = 0; m_foul = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_idle();
            m_vd = 0;
        end else begin
            bit tk, dec, f1, f2;
            int n1, n2;
            tk = vsync_in && !m_vd;
            m_vd = vsync_in;
            if (m_st != 0 && keyboard_in[3]) begin
                model_idle();
            end else begin
                case (m_st)
                    0: if (start_game || keyboard_in[2]) begin
                        m_st = 1; m_cd = 3; m_fr = 0;
                    end
                    1: begin
                        if (keyboard_in[0] || keyboard_in[1]) begin
                            m_st = 3; m_foul = 1; m_cd = 0; m_fr = 0;
                            m_win = (keyboard_in[0] && keyboard_in[1]) ? 3 : (keyboard_in[0] ? 2 : 1);
                        end else if (tk) begin
                            m_fr = m_fr + 1;
                            if (m_fr == 60) begin
                                m_fr = 0;
                                m_cd = m_cd - 1;
                                if (m_cd == 0) begin
                                    m_st = 2; m_dc = 0;
                                end
                            end
                        end
                    end
                    2: begin
                        dec = 0;
                        if (tk) begin
                            m_dc = m_dc + 1;
                            if (m_dc == 8) begin
                                dec = 1; m_dc = 0;
                            end
                        end
                        n1 = m_x1; n2 = m_x2;
                        if (tk) begin
                            n1 = (m_x1 + m_s1 > 900) ? 900 : m_x1 + m_s1;
                            n2 = (m_x2 + m_s2 > 900) ? 900 : m_x2 + m_s2;
                        end
                        m_s1 = clamp_speed(m_s1 + (keyboard_in[0] ? 2 : 0) - ((dec && m_s1 > 0) ? 1 : 0));
                        m_s2 = clamp_speed(m_s2 + (keyboard_in[1] ? 2 : 0) - ((dec && m_s2 > 0) ? 1 : 0));
                        f1 = tk && (n1 == 900);
                        f2 = tk && (n2 == 900);
                        m_x1 = n1; m_x2 = n2;
                        if (f1 || f2) begin
                            m_st = 3;
                            m_win = (f1 && f2) ? 3 : (f1 ? 1 : 2);
                        end
                    end
                    default: begin
                        m_s1 = 0; m_s2 = 0;
                        if (keyboard_in[2]) model_idle();
                    end
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("xpos_p1", xpos_p1, m_x1);
        chk("xpos_p2", xpos_p2, m_x2);
        chk("mov_p1", mov_p1, (m_s1 != 0));
        chk("mov_p2", mov_p2, (m_s2 != 0));
        chk("countdown", countdown, m_cd);
        chk("race_active", race_active, (m_st == 2));
        chk("winner", winner, m_win);
        chk("foul", foul, m_foul);
        chk("in_menu", in_menu, (m_st == 0));
    end

    task automatic step(input logic [3:0] k, input logic sg, input logic vs);
        @(negedge clk);
        keyboard_in = k;
        start_game = sg;
        vsync_in = vs;
    endtask

    // One video frame: the tick lands on the edge that sees vsync high, with keys k.
    task automatic frame(input logic [3:0] k);
        step(k, 1'b0, 1'b1);
        step(4'd0, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [3:0] k);
        step(k, 1'b0, 1'b0);
        step(4'd0, 1'b0, 1'b0);
    endtask

    task automatic start_race();
        step(4'd0, 1'b1, 1'b0);
        step(4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 180; i++) frame(4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        step(4'd0, 1'b0, 1'b0);
        step(4'd0, 1'b0, 1'b0);
        chk("rst_xpos_p1", xpos_p1, 256);
        chk("rst_in_menu", in_menu, 1);
        rst = 1'b0;

        // Countdown with no taps
        step(4'd0, 1'b1, 1'b0);
        step(4'd0, 1'b0, 1'b0);
        chk("cd_start", countdown, 3);
        for (int i = 1; i <= 180; i++) begin
            frame(4'd0);
            if (i == 59)  chk("cd_tick59", countdown, 3);
            if (i == 60)  chk("cd_tick60", countdown, 2);
            if (i == 120) chk("cd_tick120", countdown, 1);
            if (i == 179) chk("race_tick179", race_active, 0);
        end
        chk("race_tick180", race_active, 1);
        chk("cd_zero", countdown, 0);
        chk("xpos_hold", xpos_p1, 256);

        // Five taps then a tick, then decay on ticks 8 and 16
        for (int i = 0; i < 5; i++) step(4'b0001, 1'b0, 1'b0);
        step(4'd0, 1'b0, 1'b0);
        frame(4'd0);
        chk("xpos_266", xpos_p1, 266);
        chk("mov_p1_on", mov_p1, 1);
        chk("mov_p2_off", mov_p2, 0);
        for (int i = 2; i <= 17; i++) frame(4'd0);
        chk("xpos_decay", xpos_p1, 416);

        // Asynchronous reset mid-race, observed before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("arst_xpos_p1", xpos_p1, 256);
        chk("arst_race_active", race_active, 0);
        chk("arst_in_menu", in_menu, 1);
        chk("arst_mov_p1", mov_p1, 0);
        step(4'd0, 1'b0, 1'b0);
        step(4'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // False start by P1 during countdown=2
        step(4'd0, 1'b1, 1'b0);
        step(4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) frame(4'd0);
        chk("fs_cd2", countdown, 2);
        press(4'b0001);
        chk("fs_winner", winner, 2);
        chk("fs_foul", foul, 1);
        press(4'b0100);
        chk("fs_confirm_menu", in_menu, 1);
        chk("fs_confirm_winner", winner, 0);

        // Simultaneous false start, started with the confirm key
        press(4'b0100);
        for (int i = 0; i < 5; i++) frame(4'd0);
        press(4'b0011);
        chk("fs_tie_winner", winner, 3);
        chk("fs_tie_foul", foul, 1);
        press(4'b0100);

        // Both players identical: tie at the line
        start_race();
        n = 0;
        while (m_st == 2 && n < 100) begin frame(4'b0011); n++; end
        chk("tie_bound", (n < 100), 1);
        chk("tie_x1", xpos_p1, 900);
        chk("tie_x2", xpos_p2, 900);
        chk("tie_winner", winner, 3);
        press(4'b0100);

        // P1 alone saturates at the finish
        start_race();
        n = 0;
        while (m_st == 2 && n < 100) begin frame(4'b0001); n++; end
        chk("p1_bound", (n < 100), 1);
        chk("p1_winner", winner, 1);
        chk("p1_x1", xpos_p1, 900);
        chk("p1_x2", xpos_p2, 256);
        press(4'b0100);

        // Abort on the finishing tick wins over the finish
        start_race();
        n = 0;
        while (m_x1 + m_s1 < 900 && n < 100) begin frame(4'b0011); n++; end
        chk("abort_bound", (n < 100), 1);
        frame(4'b1011);
        chk("abort_winner", winner, 0);
        chk("abort_menu", in_menu, 1);
        chk("abort_x1", xpos_p1, 256);

        // Tap and tick together from standstill
        start_race();
        frame(4'b0001);
        chk("tt_x1", xpos_p1, 256);
        chk("tt_mov", mov_p1, 1);
        frame(4'd0);
        chk("tt_x1_next", xpos_p1, 258);
        press(4'b1000);
        chk("tt_abort_menu", in_menu, 1);

        step(4'd0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
